// File: rtl/word_splitter_pkg.sv
// Shared types and helpers for word_splitter: FSM state encoding,
// byte-order selectors and the byte parity function.
package word_splitter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_e;

    localparam int unsigned BYTE_ORDER_LOW_FIRST  = 0;
    localparam int unsigned BYTE_ORDER_HIGH_FIRST = 1;

    function automatic logic [7:0] first_byte(input logic [15:0] w, input logic high_first);
        return high_first ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] w, input logic high_first);
        return high_first ? w[7:0] : w[15:8];
    endfunction

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/word_splitter.sv
// Splits 16-bit words into a two-byte stream with valid/ready handshakes.
// Define WORD_SPLITTER_PARITY_EN to add the registered data_parity output.
module word_splitter
    import word_splitter_pkg::*;
#(
    parameter int unsigned BYTE_ORDER = BYTE_ORDER_LOW_FIRST,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      result,
    input  logic             result_valid,
    output logic             result_ready,
    output logic [7:0]       data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic [CNT_W-1:0] word_count
`ifdef WORD_SPLITTER_PARITY_EN
    ,
    output logic             data_parity
`endif
);

    localparam logic HIGH_FIRST = (BYTE_ORDER == BYTE_ORDER_HIGH_FIRST);

    state_e           state_q, state_d;
    logic [7:0]       second_q, second_d;
    logic [7:0]       data_out_q, data_out_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            second_q   <= '0;
            data_out_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            second_q   <= second_d;
            data_out_q <= data_out_d;
            count_q    <= count_d;
        end
    end

    // SECOND with a ready consumer can take the next word in the same cycle.
    always_comb begin
        result_ready = (state_q == IDLE) || ((state_q == SECOND) && data_ready);
    end

    always_comb begin
        state_d    = state_q;
        second_d   = second_q;
        data_out_d = data_out_q;
        count_d    = count_q;
        unique case (state_q)
            IDLE: begin
                if (result_valid) begin
                    state_d    = FIRST;
                    data_out_d = first_byte(result, HIGH_FIRST);
                    second_d   = second_byte(result, HIGH_FIRST);
                end
            end
            FIRST: begin
                if (data_ready) begin
                    state_d    = SECOND;
                    data_out_d = second_q;
                end
            end
            SECOND: begin
                if (data_ready) begin
                    count_d = count_q + CNT_W'(1);
                    if (result_valid) begin
                        state_d    = FIRST;
                        data_out_d = first_byte(result, HIGH_FIRST);
                        second_d   = second_byte(result, HIGH_FIRST);
                    end else begin
                        state_d    = IDLE;
                        data_out_d = '0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                data_out_d = '0;
            end
        endcase
    end

    assign data_out   = data_out_q;
    assign data_valid = (state_q != IDLE);
    assign word_count = count_q;

`ifdef WORD_SPLITTER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= even_parity(data_out_d);
        end
    end

    assign data_parity = parity_q;
`endif

endmodule
